// File: rtl/mem_dbg_pkg.sv
// rtl/mem_dbg_pkg.sv - shared types and constants for the memory-bus debug master
package mem_dbg_pkg;

    localparam int WORD_BYTES = 4;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/mem_dbg_master.sv
// rtl/mem_dbg_master.sv - debug initiator issuing single/burst reads and fills on the CPU memory bus
module mem_dbg_master
    import mem_dbg_pkg::*;
#(
    parameter int READ_LATENCY = 1,
    parameter int LEN_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              rsp_valid,
    output logic              rsp_last,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              done,
    output logic              err_align,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic              memread,
    output logic              memwrite,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam int              LAT_W    = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY);
    localparam bit              ZERO_LAT = (READ_LATENCY == 0);

    state_t             state;
    state_t             state_nxt;
    logic               ready_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic [LEN_W-1:0]   remaining_q;
    logic [LAT_W-1:0]   lat_cnt;
    logic               err_align_q;
    logic               rsp_valid_q;
    logic               rsp_last_q;
    logic [DATA_W-1:0]  rsp_rdata_q;

    logic accept;
    logic aligned;
    logic issue_fire;
    logic lat_hit;
    logic last_beat;
    logic capture;

    assign accept     = (state == IDLE) && cmd_valid && ready_q;
    assign aligned    = (cmd_addr[1:0] == 2'b00);
    // A strobe only fires while the grant is held in the same cycle
    assign issue_fire = (state == ISSUE) && bus_gnt;
    assign lat_hit    = (state == WAIT) && (lat_cnt == LAT_LAST);
    assign last_beat  = (remaining_q == '0);
    assign capture    = ZERO_LAT ? (issue_fire && !wr_q) : lat_hit;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept && aligned) state_nxt = REQ;
            REQ:     if (bus_gnt) state_nxt = ISSUE;
            ISSUE: begin
                if (!bus_gnt)               state_nxt = REQ;
                else if (wr_q || ZERO_LAT)  state_nxt = NEXT;
                else                        state_nxt = WAIT;
            end
            WAIT:    if (lat_hit) state_nxt = NEXT;
            NEXT: begin
                if (last_beat)    state_nxt = DONE;
                else if (bus_gnt) state_nxt = ISSUE;
                else              state_nxt = REQ;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
            lat_cnt     <= '0;
            err_align_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            ready_q     <= (state_nxt == IDLE);
            err_align_q <= accept && !aligned;
            rsp_valid_q <= capture;
            rsp_last_q  <= capture && last_beat;
            if (capture) rsp_rdata_q <= mem_readdata;
            if (accept && aligned) begin
                wr_q        <= cmd_write;
                addr_q      <= cmd_addr;
                wdata_q     <= cmd_wdata;
                remaining_q <= cmd_len;
            end
            if (issue_fire)
                lat_cnt <= LAT_W'(1);
            else if ((state == WAIT) && !lat_hit)
                lat_cnt <= lat_cnt + 1'b1;
            // Address wraps modulo 2^32 by construction
            if ((state == NEXT) && !last_beat) begin
                addr_q      <= addr_q + ADDR_W'(WORD_BYTES);
                remaining_q <= remaining_q - 1'b1;
            end
        end
    end

    assign cmd_ready     = ready_q;
    assign err_align     = err_align_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_last      = rsp_last_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign done          = (state == DONE);
    assign bus_req       = (state == REQ) || (state == ISSUE) || (state == WAIT) ||
                           ((state == NEXT) && !last_beat);
    assign memread       = issue_fire && !wr_q;
    assign memwrite      = issue_fire && wr_q;
    assign mem_addr      = issue_fire ? addr_q : '0;
    assign mem_writedata = memwrite ? wdata_q : '0;

endmodule

// File: tb/tb_mem_dbg_master.sv
// tb/tb_mem_dbg_master.sv - randomized self-checking bench for mem_dbg_master against a transaction-level model
module tb_mem_dbg_master;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_write = 1'b0;
    logic [31:0]      cmd_addr = '0;
    logic [31:0]      cmd_wdata = '0;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             rsp_valid;
    logic             rsp_last;
    logic [31:0]      rsp_rdata;
    logic             done;
    logic             err_align;
    logic             bus_req;
    logic             bus_gnt = 1'b1;
    logic             memread;
    logic             memwrite;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_writedata;
    logic [31:0]      mem_readdata = '0;

    mem_dbg_master #(.READ_LATENCY(1), .LEN_W(LEN_W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_len(cmd_len),
        .rsp_valid(rsp_valid), .rsp_last(rsp_last), .rsp_rdata(rsp_rdata),
        .done(done), .err_align(err_align),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .memread(memread), .memwrite(memwrite), .mem_addr(mem_addr),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } beat_t;
    typedef struct packed { logic [31:0] d; logic last; } rsp_t;

    beat_t obs_beats_q[$];
    beat_t exp_beats_q[$];
    rsp_t  obs_rsp_q[$];
    rsp_t  exp_rsp_q[$];
    int    obs_done = 0;
    int    obs_err = 0;
    int    viol = 0;
    int    req_gaps = 0;
    int    exp_beats = 0;
    int    gnt_mode = 0;
    int    drop_left = 0;
    int    checks = 0;
    int    passed = 0;
    int    fails = 0;

    logic [31:0] bus_mem [0:1023];
    bit          bus_wr  [0:1023];
    logic [31:0] ref_mem [0:1023];
    bit          ref_wr  [0:1023];

    function automatic logic [31:0] init_val(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_wr[a[11:2]] ? ref_mem[a[11:2]] : init_val(a);
    endfunction

    // Bus-side memory: one cycle read latency
    always @(posedge clk) begin
        if (memwrite) begin
            bus_mem[mem_addr[11:2]] <= mem_writedata;
            bus_wr[mem_addr[11:2]]  <= 1'b1;
        end
        if (memread)
            mem_readdata <= bus_wr[mem_addr[11:2]] ? bus_mem[mem_addr[11:2]] : init_val(mem_addr);
    end

    always @(negedge clk) begin
        if (memread || memwrite) begin
            if (!bus_gnt || (memread && memwrite) || !bus_req) viol <= viol + 1;
            obs_beats_q.push_back('{memwrite, mem_addr, mem_writedata});
        end
        if (rsp_valid) obs_rsp_q.push_back('{rsp_rdata, rsp_last});
        if (done) obs_done <= obs_done + 1;
        if (err_align) obs_err <= obs_err + 1;
        if (obs_beats_q.size() > 0 && obs_beats_q.size() < exp_beats && !bus_req)
            req_gaps <= req_gaps + 1;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (gnt_mode)
                0: bus_gnt = 1'b1;
                1: bus_gnt = ($urandom_range(0, 3) != 0);
                default: begin
                    if (obs_beats_q.size() >= 1 && drop_left > 0) begin
                        bus_gnt = 1'b0;
                        drop_left--;
                    end else begin
                        bus_gnt = 1'b1;
                    end
                end
            endcase
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (#%0d)", tag, obs, exp, fails);
        end
    endtask

    function automatic logic [127:0] outs();
        return {cmd_ready, rsp_valid, rsp_last, rsp_rdata, done, err_align, bus_req,
                memread, memwrite, mem_addr, mem_writedata};
    endfunction

    task automatic run_cmd(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input int len, input string tag);
        int          n;
        int          base_done;
        int          base_err;
        int          base_viol;
        int          base_gaps;
        bit          mis;
        logic [31:0] ai;
        mis = (a[1:0] != 2'b00);
        exp_beats_q.delete();
        exp_rsp_q.delete();
        obs_beats_q.delete();
        obs_rsp_q.delete();
        base_done = obs_done;
        base_err  = obs_err;
        base_viol = viol;
        base_gaps = req_gaps;
        if (!mis) begin
            for (int i = 0; i <= len; i++) begin
                ai = a + 32'(4 * i);
                if (w) begin
                    exp_beats_q.push_back('{1'b1, ai, wd});
                    ref_mem[ai[11:2]] = wd;
                    ref_wr[ai[11:2]]  = 1'b1;
                end else begin
                    exp_beats_q.push_back('{1'b0, ai, 32'h0});
                    exp_rsp_q.push_back('{ref_read(ai), (i == len)});
                end
            end
        end
        exp_beats = exp_beats_q.size();

        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = wd;
        cmd_len   = LEN_W'(len);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        check({tag, ":accept_timeout"}, n < 200, 1);
        tick();
        cmd_valid = 1'b0;
        check({tag, ":ready_after_accept"}, cmd_ready, mis);

        n = 0;
        while (obs_done == base_done && obs_err == base_err && n < 2000) begin tick(); n++; end
        check({tag, ":complete_timeout"}, n < 2000, 1);
        if (!mis && obs_done != base_done) begin
            check({tag, ":ready_in_done"}, cmd_ready, 0);
            tick();
            check({tag, ":ready_after_done"}, cmd_ready, 1);
        end
        repeat (4) tick();

        check({tag, ":beat_count"}, obs_beats_q.size(), exp_beats_q.size());
        for (int i = 0; i < exp_beats_q.size(); i++)
            if (i < obs_beats_q.size()) check({tag, ":beat"}, obs_beats_q[i], exp_beats_q[i]);
        check({tag, ":rsp_count"}, obs_rsp_q.size(), exp_rsp_q.size());
        for (int i = 0; i < exp_rsp_q.size(); i++)
            if (i < obs_rsp_q.size()) check({tag, ":rsp"}, obs_rsp_q[i], exp_rsp_q[i]);
        check({tag, ":done_count"}, obs_done - base_done, mis ? 0 : 1);
        check({tag, ":err_count"}, obs_err - base_err, mis ? 1 : 0);
        check({tag, ":strobe_rules"}, viol - base_viol, 0);
        check({tag, ":req_held"}, req_gaps - base_gaps, 0);
    endtask

    initial begin
        int          n;
        int          base_rsp;
        int          base_done;
        logic [31:0] a;

        repeat (3) tick();
        check("reset_outputs", outs(), '0);
        reset = 1'b0;

        gnt_mode = 0;
        run_cmd(1'b0, 32'h10, 32'h0, 0, "t1_read");
        run_cmd(1'b1, 32'h100, 32'hA5A5A5A5, 3, "t2_fill");
        run_cmd(1'b0, 32'h100, 32'h0, 3, "t2_readback");
        run_cmd(1'b0, 32'hFFFFFFFC, 32'h0, 1, "t3_wrap");

        gnt_mode  = 2;
        drop_left = 5;
        run_cmd(1'b1, 32'h180, 32'h0BADF00D, 2, "t4_gnt_drop");
        check("t4_drop_used", drop_left, 0);
        gnt_mode = 0;
        run_cmd(1'b0, 32'h180, 32'h0, 2, "t4_readback");

        run_cmd(1'b1, 32'h102, 32'h1, 0, "t5_misaligned");

        exp_beats = 0;
        obs_beats_q.delete();
        obs_rsp_q.delete();
        cmd_write = 1'b0;
        cmd_addr  = 32'h240;
        cmd_len   = LEN_W'(7);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (obs_beats_q.size() < 3 && n < 200) begin tick(); n++; end
        check("t6_reach_beat3", obs_beats_q.size(), 3);
        tick();
        reset = 1'b1;
        base_rsp  = obs_rsp_q.size();
        base_done = obs_done;
        check("t6_rsp_before_reset", base_rsp, 2);
        tick();
        check("t6_outputs_zero", outs(), '0);
        repeat (3) tick();
        reset = 1'b0;
        repeat (4) tick();
        check("t6_no_rsp", obs_rsp_q.size() - base_rsp, 0);
        check("t6_no_done", obs_done - base_done, 0);
        check("t6_beats_stopped", obs_beats_q.size(), 3);
        run_cmd(1'b0, 32'h240, 32'h0, 7, "t6_fresh");

        for (int k = 0; k < 24; k++) begin
            a = 32'h200 + 32'($urandom_range(0, 31)) * 32'd4;
            if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
            gnt_mode = int'($urandom_range(0, 1));
            run_cmd(1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 7)), "rand");
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
